// File: rtl/mtimer_pkg.sv
// Shared constants and helpers for the multi-hart machine timer:
// register offsets, CTRL field positions, reset values and byte-strobe merge.
package mtimer_pkg;

    localparam logic [31:0] MTIME_LO   = 32'h0000_0000;
    localparam logic [31:0] MTIME_HI   = 32'h0000_0004;
    localparam logic [31:0] CTRL       = 32'h0000_0010;
    localparam logic [31:0] CMP_BASE   = 32'h0000_8000;
    localparam logic [31:0] CMP_STRIDE = 32'h0000_0008;

    localparam int unsigned CTRL_EN_BIT    = 32'd0;
    localparam int unsigned CTRL_PRESC_LSB = 32'd8;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace the strobed bytes of old_v with those of new_v.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Tick generator: pulses tick_o once every (presc_i+1) enabled clocks.
module mtimer_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic               clear_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic               tick_s;

    // Count 0..presc while enabled; hold when disabled; restart on clear.
    always_comb begin
        tick_s = en_i && (cnt_q == presc_i);
        if (clear_i) begin
            cnt_d = {PRESC_W{1'b0}};
        end else if (!en_i) begin
            cnt_d = cnt_q;
        end else if (tick_s) begin
            cnt_d = {PRESC_W{1'b0}};
        end else begin
            cnt_d = cnt_q + PRESC_W'(1'b1);
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {PRESC_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = tick_s;

endmodule

// File: rtl/mtimer_multi.sv
// Machine timer for N harts: shared 64-bit mtime, per-hart mtimecmp and
// registered interrupt, APB slave with zero-wait writes and one-wait reads.
module mtimer_multi
    import mtimer_pkg::*;
#(
    parameter int N_HARTS = 4,
    parameter int PRESC_W = 8,
    parameter int ADDR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               psel,
    input  logic               penable,
    output logic               pready,
    input  logic [ADDR_W-1:0]  paddr,
    input  logic               pwrite,
    input  logic [31:0]        pwdata,
    input  logic [3:0]         pwstrb,
    output logic [31:0]        prdata,
    output logic               pslverr,
    output logic [63:0]        mtime,
    output logic [N_HARTS-1:0] mtimer_int
);

    logic [63:0]        mtime_q, mtime_d, mtime_inc_s;
    logic [63:0]        cmp_q [N_HARTS];
    logic [63:0]        cmp_d [N_HARTS];
    logic               en_q, en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               rwait_q, rwait_d;
    logic [31:0]        prdata_q, prdata_d;
    logic [N_HARTS-1:0] int_q, int_d;

    logic [ADDR_W-1:0]  waddr_s;
    logic               sel_lo_s, sel_hi_s, sel_ctrl_s, mapped_s;
    logic [N_HARTS-1:0] sel_cmp_lo_s, sel_cmp_hi_s;
    logic               rd_first_s, wr_s, ctrl_wr_s, tick_s;
    logic [31:0]        rdata_s;

    mtimer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_q),
        .presc_i (presc_q),
        .clear_i (ctrl_wr_s),
        .tick_o  (tick_s)
    );

    // Word-aligned address decode and bus handshake.
    always_comb begin
        waddr_s    = paddr & ~(ADDR_W'(2'b11));
        sel_lo_s   = (waddr_s == ADDR_W'(MTIME_LO));
        sel_hi_s   = (waddr_s == ADDR_W'(MTIME_HI));
        sel_ctrl_s = (waddr_s == ADDR_W'(CTRL));
        for (int h = 0; h < N_HARTS; h++) begin
            sel_cmp_lo_s[h] = (waddr_s == ADDR_W'(CMP_BASE + CMP_STRIDE * 32'(h)));
            sel_cmp_hi_s[h] = (waddr_s == ADDR_W'(CMP_BASE + CMP_STRIDE * 32'(h) + 32'd4));
        end
        mapped_s   = sel_lo_s | sel_hi_s | sel_ctrl_s | (|sel_cmp_lo_s) | (|sel_cmp_hi_s);
        rd_first_s = psel & penable & ~pwrite & ~rwait_q;
        wr_s       = psel & penable & pwrite & mapped_s;
        ctrl_wr_s  = wr_s & sel_ctrl_s;
        pready     = ~rd_first_s;
        pslverr    = psel & penable & ~rd_first_s & ~mapped_s;
    end

    // Register next-state: strobed writes override the ticked mtime bytes.
    always_comb begin
        mtime_inc_s = mtime_q + 64'(tick_s);
        if (wr_s && sel_lo_s) begin
            mtime_d = {mtime_inc_s[63:32], byte_merge(mtime_inc_s[31:0], pwdata, pwstrb)};
        end else if (wr_s && sel_hi_s) begin
            mtime_d = {byte_merge(mtime_inc_s[63:32], pwdata, pwstrb), mtime_inc_s[31:0]};
        end else begin
            mtime_d = mtime_inc_s;
        end

        if (ctrl_wr_s) begin
            en_d = pwstrb[CTRL_EN_BIT / 8] ? pwdata[CTRL_EN_BIT] : en_q;
            for (int b = 0; b < PRESC_W; b++) begin
                presc_d[b] = pwstrb[(CTRL_PRESC_LSB + b) / 8] ? pwdata[CTRL_PRESC_LSB + b]
                                                             : presc_q[b];
            end
        end else begin
            en_d    = en_q;
            presc_d = presc_q;
        end

        for (int h = 0; h < N_HARTS; h++) begin
            if (wr_s && sel_cmp_lo_s[h]) begin
                cmp_d[h] = {cmp_q[h][63:32], byte_merge(cmp_q[h][31:0], pwdata, pwstrb)};
            end else if (wr_s && sel_cmp_hi_s[h]) begin
                cmp_d[h] = {byte_merge(cmp_q[h][63:32], pwdata, pwstrb), cmp_q[h][31:0]};
            end else begin
                cmp_d[h] = cmp_q[h];
            end
            int_d[h] = (mtime_q >= cmp_q[h]);
        end
    end

    // Read mux (one-hot AND-OR) and the one-wait-state read pipeline.
    always_comb begin
        rdata_s = ({32{sel_lo_s}} & mtime_q[31:0]) | ({32{sel_hi_s}} & mtime_q[63:32]);
        rdata_s = rdata_s | ({32{sel_ctrl_s}} & (32'(presc_q) << CTRL_PRESC_LSB))
                          | ({32{sel_ctrl_s}} & (32'(en_q) << CTRL_EN_BIT));
        for (int h = 0; h < N_HARTS; h++) begin
            rdata_s = rdata_s | ({32{sel_cmp_lo_s[h]}} & cmp_q[h][31:0])
                              | ({32{sel_cmp_hi_s[h]}} & cmp_q[h][63:32]);
        end
        rwait_d = rd_first_s;
        if (rd_first_s) begin
            prdata_d = rdata_s;
        end else if (rwait_q) begin
            prdata_d = prdata_q;
        end else begin
            prdata_d = 32'd0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q  <= 64'd0;
            en_q     <= 1'b1;
            presc_q  <= {PRESC_W{1'b0}};
            rwait_q  <= 1'b0;
            prdata_q <= 32'd0;
            int_q    <= {N_HARTS{1'b0}};
            for (int h = 0; h < N_HARTS; h++) begin
                cmp_q[h] <= MTIMECMP_RST;
            end
        end else begin
            mtime_q  <= mtime_d;
            en_q     <= en_d;
            presc_q  <= presc_d;
            rwait_q  <= rwait_d;
            prdata_q <= prdata_d;
            int_q    <= int_d;
            for (int h = 0; h < N_HARTS; h++) begin
                cmp_q[h] <= cmp_d[h];
            end
        end
    end

    assign prdata     = prdata_q;
    assign mtime      = mtime_q;
    assign mtimer_int = int_q;

endmodule

// File: tb/tb_mtimer_multi.sv
// Directed bench for mtimer_multi: register vector table plus timing sequences.
module tb_mtimer_multi;

    localparam int N_HARTS = 4;
    localparam int NV      = 22;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               psel = 1'b0;
    logic               penable = 1'b0;
    logic               pready;
    logic [15:0]        paddr = 16'h0000;
    logic               pwrite = 1'b0;
    logic [31:0]        pwdata = 32'h0;
    logic [3:0]         pwstrb = 4'h0;
    logic [31:0]        prdata;
    logic               pslverr;
    logic [63:0]        mtime;
    logic [N_HARTS-1:0] mtimer_int;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [NV];

    mtimer_multi #(.N_HARTS(N_HARTS), .PRESC_W(8), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .psel       (psel),
        .penable    (penable),
        .pready     (pready),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pwstrb     (pwstrb),
        .prdata     (prdata),
        .pslverr    (pslverr),
        .mtime      (mtime),
        .mtimer_int (mtimer_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic rdy, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pwstrb = s;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rdy = pready;
        err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwstrb = 4'h0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        logic rdy, err;
        apb_write(a, d, s, rdy, err);
        check($sformatf("write %h pready/pslverr", a), {62'd0, rdy, err}, {62'd0, 1'b1, 1'b0});
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic err,
                            output int waits);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pwstrb = 4'h0;
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        #1;
        while (!pready && waits < 4) begin
            waits++;
            @(negedge clk);
            #1;
        end
        d = prdata;
        err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rd_check(input string nm, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        err;
        int          waits;
        apb_read(a, d, err, waits);
        check({nm, " data"}, 64'(d), 64'(exp));
        check({nm, " err/waits"}, {31'd0, err, 32'(waits)}, {31'd0, 1'b0, 32'd1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] m0, m1;
        logic [31:0] d;
        logic        rdy, err;
        int          waits;

        vecs[0]  = '{16'h0000, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{16'h0000, 1'b0, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{16'h0004, 1'b1, 32'hCAFE1234, 4'hC, 32'h0, 1'b0};
        vecs[3]  = '{16'h0004, 1'b0, 32'h0,        4'h0, 32'hCAFE0000, 1'b0};
        vecs[4]  = '{16'h8008, 1'b1, 32'h12345678, 4'h5, 32'h0, 1'b0};
        vecs[5]  = '{16'h8008, 1'b0, 32'h0,        4'h0, 32'hFF34FF78, 1'b0};
        vecs[6]  = '{16'h800C, 1'b0, 32'h0,        4'h0, 32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{16'h8000, 1'b1, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0};
        vecs[8]  = '{16'h8000, 1'b0, 32'h0,        4'h0, 32'hAABBCCDD, 1'b0};
        vecs[9]  = '{16'h8004, 1'b1, 32'h11223344, 4'h8, 32'h0, 1'b0};
        vecs[10] = '{16'h8004, 1'b0, 32'h0,        4'h0, 32'h11FFFFFF, 1'b0};
        vecs[11] = '{16'h8018, 1'b1, 32'h00000000, 4'h0, 32'h0, 1'b0};
        vecs[12] = '{16'h8018, 1'b0, 32'h0,        4'h0, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{16'h0010, 1'b1, 32'hFFFFFFFE, 4'hF, 32'h0, 1'b0};
        vecs[14] = '{16'h0010, 1'b0, 32'h0,        4'h0, 32'h0000FF00, 1'b0};
        vecs[15] = '{16'h8020, 1'b0, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[16] = '{16'h8020, 1'b1, 32'h00000000, 4'hF, 32'h0, 1'b1};
        vecs[17] = '{16'h0008, 1'b0, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[18] = '{16'h0014, 1'b1, 32'h55555555, 4'hF, 32'h0, 1'b1};
        vecs[19] = '{16'h000C, 1'b0, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[20] = '{16'h801C, 1'b0, 32'h0,        4'h0, 32'hFFFFFFFF, 1'b0};
        vecs[21] = '{16'h8002, 1'b0, 32'h0,        4'h0, 32'hAABBCCDD, 1'b0};

        // Reset, free-running count and first read latency.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mtime after 10 clocks", mtime, 64'd10);
        check("int after reset", 64'(mtimer_int), 64'd0);
        rd_check("cmp0 hi reset", 16'h8004, 32'hFFFFFFFF);

        // Carry into the high word and full 64-bit wrap.
        wr(16'h0010, 32'h0, 4'hF);
        wr(16'h0000, 32'hFFFFFFFF, 4'hF);
        wr(16'h0004, 32'h0, 4'hF);
        check("mtime frozen after writes", mtime, 64'h0000_0000_FFFF_FFFF);
        wr(16'h0010, 32'h1, 4'hF);
        check("mtime no tick on enable edge", mtime, 64'h0000_0000_FFFF_FFFF);
        @(posedge clk); #1;
        check("mtime carry", mtime, 64'h0000_0001_0000_0000);
        wr(16'h0010, 32'h0, 4'hF);
        wr(16'h0004, 32'hFFFFFFFF, 4'hF);
        wr(16'h0000, 32'hFFFFFFFF, 4'hF);
        wr(16'h0010, 32'h1, 4'hF);
        check("int at mtime max", 64'(mtimer_int), 64'hF);
        @(posedge clk); #1;
        check("mtime wrap", mtime, 64'd0);
        @(posedge clk); #1;
        check("int after wrap", 64'(mtimer_int), 64'd0);

        // Prescaler divide-by-4, then freeze.
        wr(16'h0010, 32'h0000_0301, 4'h3);
        m0 = mtime;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("presc3 k=%0d", k), mtime, m0 + 64'(k / 4));
        end
        wr(16'h0010, 32'h0000_0300, 4'h3);
        m1 = mtime;
        repeat (20) @(posedge clk);
        #1;
        check("mtime frozen 20 clocks", mtime, m1);
        rd_check("frozen mtime lo", 16'h0000, m1[31:0]);
        rd_check("frozen mtime hi", 16'h0004, m1[63:32]);

        // Register vector table (mtime frozen).
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, rdy, err);
                check($sformatf("vec%0d write", i), {62'd0, rdy, err}, {62'd0, 1'b1, vecs[i].exp_err});
            end else begin
                apb_read(vecs[i].addr, d, err, waits);
                check($sformatf("vec%0d rdata", i), 64'(d), 64'(vecs[i].exp_rdata));
                check($sformatf("vec%0d err/waits", i), {31'd0, err, 32'(waits)},
                      {31'd0, vecs[i].exp_err, 32'd1});
            end
        end
        check("mtime after table", mtime, 64'hCAFE_0000_DEAD_BEEF);
        check("int0 from table cmp", 64'(mtimer_int), 64'h1);

        // Single-hart interrupt at mtime == 50.
        wr(16'h0004, 32'h0, 4'hF);
        wr(16'h0000, 32'd40, 4'hF);
        wr(16'h8000, 32'hFFFFFFFF, 4'hF);
        wr(16'h8004, 32'hFFFFFFFF, 4'hF);
        wr(16'h8014, 32'h0, 4'hF);
        wr(16'h8010, 32'd50, 4'hF);
        check("int idle before enable", 64'(mtimer_int), 64'd0);
        wr(16'h0010, 32'h1, 4'hF);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("irq mtime k=%0d", k), mtime, 64'd40 + 64'(k));
            check($sformatf("irq int k=%0d", k), 64'(mtimer_int), (k >= 11) ? 64'h4 : 64'h0);
        end
        wr(16'h8014, 32'h1, 4'hF);
        check("int2 before fall", 64'(mtimer_int), 64'h4);
        @(posedge clk); #1;
        check("int2 after cmp raise", 64'(mtimer_int), 64'h0);

        // Reset during the read wait state.
        wr(16'h0010, 32'h0000_0500, 4'hF);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0010;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check("pready low in read wait", 64'(pready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        #1;
        check("rst pready/pslverr", {62'd0, pready, pslverr}, {62'd0, 1'b1, 1'b0});
        check("rst prdata", 64'(prdata), 64'd0);
        check("rst mtime", mtime, 64'd0);
        check("rst int", 64'(mtimer_int), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_check("ctrl after rst", 16'h0010, 32'h0000_0001);
        rd_check("cmp2 hi after rst", 16'h8014, 32'hFFFFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtimer_multi.md
Name: mtimer_multi

Overview:
Parametrised machine-timer block serving N harts from one shared 64-bit mtime counter. Each hart has its own 64-bit mtimecmp and interrupt line. Adds a programmable tick prescaler, a global count enable, byte-strobe writes, error response on unmapped addresses, and registered interrupts. Sits on the peripheral APB bus; mtime is fed directly to all cores for the time CSR.

Parameters:
N_HARTS, 4, number of mtimecmp channels and interrupt outputs (1..16)
PRESC_W, 8, width of prescaler divide field; tick every (presc+1) clocks
ADDR_W, 16, APB address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
psel  in  1  APB select
penable  in  1  APB enable
pready  out  1  APB ready
paddr  in  ADDR_W  APB byte address
pwrite  in  1  APB write
pwdata  in  32  APB write data
pwstrb  in  4  APB byte strobes
prdata  out  32  APB read data
pslverr  out  1  APB error
mtime  out  64  current time to all cores
mtimer_int  out  N_HARTS  per-hart machine timer interrupt

Behaviour:
- Reset (rst=1 at posedge clk): mtime=0; mtimecmp[h]=64'hFFFF_FFFF_FFFF_FFFF; ctrl.en=1; ctrl.presc=0; prescale counter=0; mtimer_int=0; prdata=0; read-wait flag cleared.
- Address map (32-bit words, paddr[1:0] ignored): 0x0000 mtime[31:0]; 0x0004 mtime[63:32]; 0x0010 CTRL {bit0 en, bits[8+PRESC_W-1:8] presc, others RAZ/WI}; 0x8000+8h mtimecmp[h][31:0]; 0x8004+8h mtimecmp[h][63:32], for h < N_HARTS. Any other address is unmapped.
- Prescaler: when en=1, an internal counter counts 0..presc. tick=1 on the cycle the counter equals presc, and the counter then returns to 0. When en=0, the counter holds and tick=0. A CTRL write clears the counter to 0.
- mtime: increments by 1 on tick and wraps 2^64-1 -> 0. An APB write to an mtime word overwrites only the strobed bytes. All other bytes of the 64-bit value take (mtime + tick) in the same cycle, so carry from the incremented value is not lost. A write takes priority over the tick for the strobed bytes.
- mtimecmp/CTRL writes: byte-granular per pwstrb. pwstrb=0 is a legal no-op.
- Writes: zero wait state. pready=1 in the access cycle; the register updates at that clock edge.
- Reads: one wait state.
  - First access cycle (psel&penable&~pwrite, wait flag clear): pready=0, and prdata is registered from the decoded address.
  - Second cycle: pready=1 and prdata is valid.
  - The wait flag clears when pready is asserted, or when psel drops.
- pslverr: asserted together with pready only for an unmapped address, on both reads and writes. On an error, writes have no effect and prdata=0. Partial strobes are not an error.
- Interrupt: mtimer_int[h] is registered as (mtime >= mtimecmp[h]), unsigned 64-bit, evaluated on the current mtime. Latency is one clock after the value change. A write that raises mtimecmp above mtime deasserts the interrupt on the following cycle.
- A 64-bit mtimecmp update is not atomic. Software writes high word 0xFFFFFFFF first. The hardware gives no protection.
- Reset asserted mid-transfer: pready returns to 1 (idle), the read wait is aborted and all state takes its reset values. A transfer in progress is lost.

Decomposition:
- Package mtimer_pkg holds:
  - address offsets MTIME_LO/HI, CTRL, CMP_BASE, CMP_STRIDE
  - CTRL bit positions
  - the mtimecmp reset constant
  - function byte_merge(old, new, strb)
- Sub-module mtimer_prescaler: en, presc, clear in; tick out.

Test Plan:
- Reset, then 10 clocks, presc=0 -> mtime=10; mtimer_int=0; read 0x8004 returns 0xFFFFFFFF with pready low for exactly 1 cycle.
- Write mtime lo=0xFFFFFFFF, hi=0; after 1 tick -> mtime=0x1_0000_0000. Write hi=0xFFFFFFFF, lo=0xFFFFFFFF -> wraps to 0 on the next tick.
- CTRL presc=3, en=1 -> mtime advances exactly 1 per 4 clocks. en=0 -> mtime frozen for 20 clocks; reading it back returns the same value.
- mtimecmp[2]=50 with others max -> only mtimer_int[2] rises, 1 cycle after mtime reaches 50. Writing mtimecmp[2] hi=1 -> it falls the next cycle.
- Write 0x12345678 to mtimecmp[1] lo with pwstrb=4'b0101 -> value 0xFF34FF78. Read of address 0x8000+8*N_HARTS -> pslverr=1, prdata=0.
- rst asserted during the read wait cycle -> pready=1 next cycle, all registers at reset values, no stale pready/pslverr.
